// File: rtl/fpu_issue_sequencer_if.sv
// Bus bundle between a requester, the issue sequencer and the fixed-point unit.
// Handshake rule for both req and rsp channels: a transfer happens on a rising
// clk edge where valid && ready are both 1; valid may not depend on ready, and
// the payload must be stable while valid is high and ready is low.
interface fpu_issue_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_op_a;
  logic [WIDTH-1:0] req_op_b;
  logic [1:0]       req_operation;
  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_error;

  // requester / environment side
  modport master (
    output req_valid, req_op_a, req_op_b, req_operation, fpu_result, fpu_ready, rsp_ready,
    input  req_ready, fpu_operand_1, fpu_operand_2, fpu_operation, rsp_valid, rsp_result, rsp_error
  );

  // sequencer side
  modport slave (
    input  req_valid, req_op_a, req_op_b, req_operation, fpu_result, fpu_ready, rsp_ready,
    output req_ready, fpu_operand_1, fpu_operand_2, fpu_operation, rsp_valid, rsp_result, rsp_error
  );
endinterface

// File: rtl/fpu_issue_sequencer.sv
// Issue sequencer for a fixed-point unit: accepts one request, holds the
// operands/operation for the unit, waits for its result and presents it as a
// response until the consumer takes it. One request outstanding at a time.
// Optional feature: define FPU_SEQ_TIMEOUT_EN to abort a WAIT after TIMEOUT
// cycles with rsp_error=1 and rsp_result=0.
`ifndef FPU_ADD
`define FPU_ADD  2'b00
`endif
`ifndef FPU_SUB
`define FPU_SUB  2'b01
`endif
`ifndef FPU_MUL
`define FPU_MUL  2'b10
`endif
`ifndef FPU_SQRT
`define FPU_SQRT 2'b11
`endif

module fpu_issue_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  fpu_issue_sequencer_if.slave bus,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One spare bit so the counter can always represent TIMEOUT and at least 2.
  localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic [1:0]       op_q;
  logic             error_q;
  logic             ready_ok;
  logic             timeout_hit;

  // A square root result is not trusted during its first two WAIT cycles.
  assign ready_ok = bus.fpu_ready &&
                    !((op_q == `FPU_SQRT) && (wait_cnt < CNT_W'(2)));

`ifdef FPU_SEQ_TIMEOUT_EN
  // The counter value after this cycle's increment would reach TIMEOUT.
  assign timeout_hit = (wait_cnt >= CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset drops any outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (ready_ok || timeout_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_q     <= `FPU_ADD;
      wait_cnt <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        op_a_q <= bus.req_op_a;
        op_b_q <= bus.req_op_b;
        op_q   <= bus.req_operation;
      end
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
        if (ready_ok) begin
          result_q <= bus.fpu_result;
          error_q  <= 1'b0;
        end else if (timeout_hit) begin
          result_q <= '0;
          error_q  <= 1'b1;
        end
      end
    end
  end

  // The operation code falls back to ADD outside ISSUE/WAIT so a square root
  // is never retriggered by a lingering code.
  assign bus.fpu_operation = (state == ISSUE || state == WAIT) ? op_q : `FPU_ADD;
  assign bus.fpu_operand_1 = op_a_q;
  assign bus.fpu_operand_2 = op_b_q;
  assign bus.req_ready     = (state == IDLE) && !reset;
  assign bus.rsp_valid     = (state == RESP);
  assign bus.rsp_result    = result_q;
`ifdef FPU_SEQ_TIMEOUT_EN
  assign bus.rsp_error     = error_q;
`else
  assign bus.rsp_error     = 1'b0;
`endif
  assign busy              = (state != IDLE);
  assign state_dbg         = state;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed bench for fpu_issue_sequencer. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_fpu_issue_sequencer;
  localparam int W = 32;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_SQRT = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] state_dbg;
  int         total = 0;
  int         bad = 0;
  logic [W-1:0] exp_q[$];

  fpu_issue_sequencer_if #(.WIDTH(W)) bus ();

  fpu_issue_sequencer #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req_valid     = 1'b0;
    bus.req_op_a      = '0;
    bus.req_op_b      = '0;
    bus.req_operation = OP_ADD;
    bus.fpu_result    = '0;
    bus.fpu_ready     = 1'b0;
    bus.rsp_ready     = 1'b0;
  endtask

  // Present a request at the current falling edge and confirm it lands in ISSUE.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid     = 1'b1;
    bus.req_op_a      = a;
    bus.req_op_b      = b;
    bus.req_operation = op;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("state_issue", state_dbg, S_ISSUE);
    check("operand_1", bus.fpu_operand_1, a);
    check("operand_2", bus.fpu_operand_2, b);
    check("operation_issue", bus.fpu_operation, op);
  endtask

  // Check the pending response against the scoreboard and consume it.
  task automatic take_rsp(input logic err_exp);
    logic [W-1:0] exp;
    check("exp_q_nonempty", (exp_q.size() != 0), 1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_result", bus.rsp_result, exp);
    check("rsp_error", bus.rsp_error, err_exp);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("state_idle_after_rsp", state_dbg, S_IDLE);
    check("rsp_valid_dropped", bus.rsp_valid, 0);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int busy_low;
    int unstable;
    int rdy_high;
    int op_wrong;
    int rv_seen;
    drive_idle();

    // reset state, checked while reset is still asserted
    reset = 1'b1;
    #3;
    check("rst_state", state_dbg, S_IDLE);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_operation", bus.fpu_operation, OP_ADD);
    check("rst_operand_1", bus.fpu_operand_1, 0);
    check("rst_req_ready", bus.req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("req_ready_after_rst", bus.req_ready, 1);
    @(negedge clk);

    // spurious fpu_ready in IDLE
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = 32'h0000_DEAD;
    @(negedge clk);
    check("idle_spurious_state", state_dbg, S_IDLE);
    check("idle_spurious_rsp", bus.rsp_valid, 0);

    // ADD 3.0 + 1.0, unit ready immediately: E0 accept, E1 WAIT, E2 RESP
    bus.fpu_result = 32'h0000_1000;
    exp_q.push_back(32'h0000_1000);
    accept(32'h0000_0C00, 32'h0000_0400, OP_ADD);
    check("add_rsp_not_early", bus.rsp_valid, 0);
    @(negedge clk);
    check("add_state_wait", state_dbg, S_WAIT);
    check("add_rsp_not_yet", bus.rsp_valid, 0);
    @(negedge clk);
    bus.fpu_ready = 1'b0;
    take_rsp(1'b0);

    // SQRT 4.0: fpu_ready ignored in WAIT cycles 0-1, real result at cycle 20
    exp_q.push_back(32'h0000_0800);
    accept(32'h0000_1000, 32'h0000_0000, OP_SQRT);
    @(negedge clk);
    check("sqrt_wait0", state_dbg, S_WAIT);
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = 32'h0000_0BAD;
    @(negedge clk);
    check("sqrt_wait1", state_dbg, S_WAIT);
    @(negedge clk);
    check("sqrt_wait2", state_dbg, S_WAIT);
    bus.fpu_ready = 1'b0;
    busy_low = 0;
    op_wrong = 0;
    for (int i = 2; i < 20; i++) begin
      if (busy !== 1'b1 || state_dbg !== S_WAIT) busy_low++;
      if (bus.fpu_operation !== OP_SQRT) op_wrong++;
      @(negedge clk);
    end
    check("sqrt_busy_in_wait", busy_low, 0);
    check("sqrt_op_in_wait", op_wrong, 0);
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = 32'h0000_0800;
    @(negedge clk);
    bus.fpu_ready = 1'b0;
    check("sqrt_rsp_valid", bus.rsp_valid, 1);
    check("sqrt_op_back_add", bus.fpu_operation, OP_ADD);
    check("sqrt_busy_resp", busy, 1);

    // backpressure in RESP while a new request waits
    bus.req_valid     = 1'b1;
    bus.req_op_a      = 32'h0000_1000;
    bus.req_op_b      = 32'h0000_0400;
    bus.req_operation = OP_SUB;
    unstable = 0;
    rdy_high = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_result !== 32'h0000_0800 || state_dbg !== S_RESP) unstable++;
      if (bus.req_ready !== 1'b0) rdy_high++;
      @(negedge clk);
    end
    check("bp_result_stable", unstable, 0);
    check("bp_req_ready_low", rdy_high, 0);
    take_rsp(1'b0);
    // request still pending: accepted from IDLE now, not during the RESP handshake
    check("bp_req_ready_idle", bus.req_ready, 1);
    exp_q.push_back(32'h0000_0C00);
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = 32'h0000_0C00;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("sub_state_issue", state_dbg, S_ISSUE);
    check("sub_operand_1", bus.fpu_operand_1, 32'h0000_1000);
    check("sub_operand_2", bus.fpu_operand_2, 32'h0000_0400);
    check("sub_operation", bus.fpu_operation, OP_SUB);
    @(negedge clk);
    @(negedge clk);
    bus.fpu_ready = 1'b0;
    take_rsp(1'b0);

    // MUL 2.0 * 3.0 with the unit never answering
    bus.fpu_ready = 1'b0;
    accept(32'h0000_0800, 32'h0000_0C00, OP_MUL);
    n = 0;
    @(negedge clk);
`ifdef FPU_SEQ_TIMEOUT_EN
    while (state_dbg == S_WAIT && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("timeout_wait_cycles", n, 8);
    exp_q.push_back(32'h0000_0000);
    take_rsp(1'b1);
`else
    while (state_dbg == S_WAIT && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("no_timeout_wait_200", n, 200);
    check("no_timeout_still_wait", state_dbg, S_WAIT);
    exp_q.push_back(32'h0000_1800);
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = 32'h0000_1800;
    @(negedge clk);
    bus.fpu_ready = 1'b0;
    take_rsp(1'b0);
`endif

    // reset in the middle of a SQRT WAIT discards it
    accept(32'h0000_1000, 32'h0000_0000, OP_SQRT);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_state", state_dbg, S_IDLE);
    check("midrst_busy", busy, 0);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_rsp_result", bus.rsp_result, 0);
    check("midrst_operand_1", bus.fpu_operand_1, 0);
    check("midrst_operation", bus.fpu_operation, OP_ADD);
    @(negedge clk);
    reset = 1'b0;
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = 32'h0000_0800;
    rv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || state_dbg !== S_IDLE) rv_seen++;
    end
    check("midrst_no_rsp", rv_seen, 0);

    // ADD 1.0 + 1.0 after the reset completes normally
    exp_q.push_back(32'h0000_0800);
    accept(32'h0000_0400, 32'h0000_0400, OP_ADD);
    @(negedge clk);
    check("post_rst_wait", state_dbg, S_WAIT);
    @(negedge clk);
    bus.fpu_ready = 1'b0;
    take_rsp(1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_issue_sequencer.md
FPU_ISSUE_SEQUENCER -- requirements
Module: fpu_issue_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 The block SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before abort.
REQ-003 Port clk  input  1: clock; all state changes on rising edge.
REQ-004 Port reset  input  1: reset, asynchronous, active-high.
REQ-005 Port req_valid  input  1: an operation request is present.
REQ-006 Port req_ready  output  1: the block accepts a request this cycle.
REQ-007 Port req_op_a, req_op_b  input  WIDTH each: request operands.
REQ-008 Port req_operation  input  2: `FPU_ADD/`FPU_SUB/`FPU_MUL/`FPU_SQRT code from Defines.vh.
REQ-009 Port fpu_operand_1, fpu_operand_2  output  WIDTH each: registered operands to the fixed-point unit.
REQ-010 Port fpu_operation  output  2: registered operation code to the fixed-point unit.
REQ-011 Port fpu_result  input  WIDTH: fixed-point unit result.
REQ-012 Port fpu_ready  input  1: fixed-point unit result valid.
REQ-013 Port rsp_valid  output  1: response held for the consumer.
REQ-014 Port rsp_ready  input  1: consumer takes the response.
REQ-015 Port rsp_result  output  WIDTH: captured result.
REQ-016 Port rsp_error  output  1: the response is a timeout abort.
REQ-017 Port busy  output  1: high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one request outstanding at a time.
REQ-019 req_ready SHALL be 1 only in IDLE; req_valid && req_ready at an edge SHALL register operands and operation and move to ISSUE.
REQ-020 ISSUE SHALL last exactly one cycle, then move to WAIT with the wait counter cleared.
REQ-021 fpu_operation SHALL equal the registered code in ISSUE and WAIT and `FPU_ADD in IDLE and RESP, so that a square root is never retriggered.
REQ-022 fpu_operand_1/2 SHALL hold the last accepted operands until the next acceptance.
REQ-023 In WAIT, fpu_ready=1 SHALL capture fpu_result into rsp_result, clear rsp_error and move to RESP.
- Exception: for `FPU_SQRT, fpu_ready SHALL be ignored during the first 2 WAIT cycles.
REQ-024 The wait counter SHALL increment each WAIT cycle and saturate; it SHALL NOT wrap.
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_result/rsp_error SHALL be stable until rsp_ready=1; that edge SHALL return to IDLE.
REQ-026 req_valid in the same cycle as RESP handshake SHALL NOT be accepted; it is accepted in the following IDLE cycle at the earliest.
REQ-027 ADD/SUB/MUL latency SHALL be: acceptance edge E0, ISSUE->WAIT at E1, WAIT->RESP at E2; rsp_valid is high after E2.
REQ-028 An fpu_ready seen in IDLE, ISSUE or RESP SHALL be ignored.

Reset
REQ-029 reset SHALL immediately, without waiting for a clock edge, force IDLE and zero the wait counter, rsp_valid, rsp_error, rsp_result, fpu_operand_1/2 and busy; it SHALL set fpu_operation=`FPU_ADD and req_ready=1 once reset deasserts.
REQ-030 Reset asserted during ISSUE, WAIT or RESP SHALL discard the request; no response is produced.

Configuration
REQ-031 With macro FPU_SEQ_TIMEOUT_EN defined, WAIT SHALL move to RESP when the wait counter reaches TIMEOUT without fpu_ready; it SHALL then set rsp_error=1 and rsp_result=0.
REQ-032 Without FPU_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely and rsp_error SHALL be constant 0.

Verification
REQ-033 ADD: a=0x00000C00 (3.0), b=0x00000400 (1.0), FPU model ready in the same cycle -> rsp_valid after E2, rsp_result=0x00001000, rsp_error=0.
REQ-034 SQRT: a=0x00001000 (4.0), FPU model ready 20 cycles into WAIT -> rsp_result equals the model value; fpu_operation returns to `FPU_ADD in RESP; busy stays high throughout.
REQ-035 Backpressure: rsp_ready=0 for 10 cycles in RESP while req_valid=1 -> rsp_result stable, req_ready=0; rsp_ready=1 -> IDLE, then the next request is accepted.
REQ-036 Timeout (macro defined, TIMEOUT=8): fpu_ready held 0 -> RESP after 8 WAIT cycles with rsp_error=1, rsp_result=0; macro undefined -> stays in WAIT for 200 cycles.
REQ-037 Reset asserted mid-WAIT on a SQRT request -> all outputs reset immediately, no rsp_valid afterwards, the next ADD request completes normally.
REQ-038 Spurious fpu_ready=1 in IDLE, and in WAIT cycles 0-1 of a SQRT -> ignored; no state change.
